ccx_chunk_unit: RTL and testbench

- Chunk-serial custom-instruction (CCX) execution unit for the FazyRV ExoTiny core.
- Sits directly downstream of the core's CCX operand outputs: consumes the rs1/rs2 chunks the core streams out, and returns the result chunks plus a response strobe.
- Replaces the testbench's fixed-delay AND model with a real multi-function unit: operand deserialization, iterative execute, result serialization.
- Targets eFPGA mapping next to the chip; the core-side protocol is unchanged.

---
 rtl/ccx_chunk_unit_if.sv | 23 ++
 rtl/ccx_chunk_unit.sv | 130 +++++++++++++
 tb/tb_ccx_chunk_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ccx_chunk_unit_if.sv
// Core-side CCX channel: operand chunks and start pulse toward the unit,
// result chunks, response strobe and busy flag back to the core.
interface ccx_chunk_unit_if #(
    parameter int CHUNKSIZE = 4
);
    logic                 ccx_req;
    logic                 ccx_sel;
    logic [CHUNKSIZE-1:0] ccx_rs_a;
    logic [CHUNKSIZE-1:0] ccx_rs_b;
    logic [CHUNKSIZE-1:0] ccx_res;
    logic                 ccx_resp;
    logic                 busy;

    modport master (
        output ccx_req, ccx_sel, ccx_rs_a, ccx_rs_b,
        input  ccx_res, ccx_resp, busy
    );

    modport slave (
        input  ccx_req, ccx_sel, ccx_rs_a, ccx_rs_b,
        output ccx_res, ccx_resp, busy
    );
endinterface

// File: rtl/ccx_chunk_unit.sv
// Chunk-serial CCX execution unit: deserializes rs1/rs2, runs AND or an
// iterative shift-add MUL, and serializes the result back LSB chunk first.
//
// state | meaning
// IDLE  | waiting for ccx_req; chunk 0 captured on accept
// LOAD  | capturing operand chunks 1..N-1
// EXEC  | MUL only, 32 shift-add iterations
// DRAIN | result chunk j shown in drain cycle j, resp with chunk N-1
module ccx_chunk_unit #(
    parameter int CHUNKSIZE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ccx_chunk_unit_if.slave  ccx
);
    localparam int N = 32 / CHUNKSIZE;
    localparam logic [4:0] LOAD_LAST  = 5'(N - 1);
    localparam logic [4:0] DRAIN_LAST = 5'(N - 1);
    localparam logic [4:0] DRAIN_PRE  = 5'(N - 2);
    localparam logic [4:0] EXEC_LAST  = 5'd31;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_e;

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [31:0]          acc_q, acc_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [CHUNKSIZE-1:0] res_q, res_d;
    logic                 resp_q, resp_d;

    logic [31:0]          a_full, b_full, and_full, acc_add;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = '0;
        resp_d   = 1'b0;
        // New chunks enter at the top so chunk 0 ends up in the LSBs.
        a_full   = {ccx.ccx_rs_a, a_q[31:CHUNKSIZE]};
        b_full   = {ccx.ccx_rs_b, b_q[31:CHUNKSIZE]};
        and_full = a_full & b_full;
        acc_add  = acc_q + (b_q[0] ? a_q : 32'd0);

        case (state_q)
            IDLE: begin
                if (ccx.ccx_req) begin
                    a_d     = a_full;
                    b_d     = b_full;
                    sel_d   = ccx.ccx_sel;
                    acc_d   = '0;
                    cnt_d   = 5'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d   = a_full;
                b_d   = b_full;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d = '0;
                    if (sel_q) begin
                        acc_d   = '0;
                        state_d = EXEC;
                    end else begin
                        // acc doubles as the drain shift register; chunk 0 goes out now.
                        res_d   = and_full[CHUNKSIZE-1:0];
                        acc_d   = and_full >> CHUNKSIZE;
                        state_d = DRAIN;
                    end
                end
            end
            EXEC: begin
                acc_d = acc_add;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == EXEC_LAST) begin
                    cnt_d   = '0;
                    res_d   = acc_add[CHUNKSIZE-1:0];
                    acc_d   = acc_add >> CHUNKSIZE;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    res_d  = acc_q[CHUNKSIZE-1:0];
                    acc_d  = acc_q >> CHUNKSIZE;
                    cnt_d  = cnt_q + 5'd1;
                    resp_d = (cnt_q == DRAIN_PRE);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            resp_q  <= resp_d;
        end
    end

    assign ccx.ccx_res  = res_q;
    assign ccx.ccx_resp = resp_q;
    assign ccx.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ccx_chunk_unit.sv
// Scoreboard bench for ccx_chunk_unit at CHUNKSIZE=4 and CHUNKSIZE=8.
module tb_ccx_chunk_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccx_chunk_unit_if #(.CHUNKSIZE(4)) if4 ();
    ccx_chunk_unit_if #(.CHUNKSIZE(8)) if8 ();

    ccx_chunk_unit #(.CHUNKSIZE(4)) dut4 (.clk_i(clk), .rst_i(rst), .ccx(if4));
    ccx_chunk_unit #(.CHUNKSIZE(8)) dut8 (.clk_i(clk), .rst_i(rst), .ccx(if8));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb4[$];
    exp_t        sb8[$];
    logic [31:0] sh4 = '0;
    logic [31:0] sh8 = '0;

    // Core-side model: right-shift every result chunk in, take the word on resp.
    always @(negedge clk) begin : mon4
        logic [31:0] nx;
        exp_t        e;
        nx  = {if4.ccx_res, sh4[31:4]};
        sh4 <= nx;
        if (!rst && if4.ccx_resp) begin
            if (sb4.size() == 0) chk("resp4_unexpected", 32'd1, 32'd0);
            else begin
                e = sb4.pop_front();
                chk("res4", nx, e.res);
                chk("lat4", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [31:0] nx;
        exp_t        e;
        nx  = {if8.ccx_res, sh8[31:8]};
        sh8 <= nx;
        if (!rst && if8.ccx_resp) begin
            if (sb8.size() == 0) chk("resp8_unexpected", 32'd1, 32'd0);
            else begin
                e = sb8.pop_front();
                chk("res8", nx, e.res);
                chk("lat8", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input bit d8, input bit req, input bit sel,
                         input logic [31:0] a, input logic [31:0] b, input int k);
        if (d8) begin
            if8.ccx_req  = req;
            if8.ccx_sel  = sel;
            if8.ccx_rs_a = 8'(a >> (k * 8));
            if8.ccx_rs_b = 8'(b >> (k * 8));
        end else begin
            if4.ccx_req  = req;
            if4.ccx_sel  = sel;
            if4.ccx_rs_a = 4'(a >> (k * 4));
            if4.ccx_rs_b = 4'(b >> (k * 4));
        end
    endtask

    // Called right after a negedge; that cycle is cycle 0. Returns in cycle N.
    task automatic issue(input bit d8, input bit sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] mask);
        int   n;
        exp_t e;
        n     = d8 ? 4 : 8;
        e.res = sel ? (a * b) : (a & b);
        e.cyc = cyc + (sel ? 2 * n + 31 : 2 * n - 1);
        if (d8) sb8.push_back(e);
        else    sb4.push_back(e);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk(d8 ? "load_res8" : "load_res4",
                    d8 ? 32'(if8.ccx_res) : 32'(if4.ccx_res), 32'd0);
                chk(d8 ? "load_busy8" : "load_busy4",
                    d8 ? 32'(if8.busy) : 32'(if4.busy), 32'd1);
            end
            drive(d8, (k == 0) || mask[k], (k == 0) ? sel : 1'($urandom), a, b, k);
        end
        @(negedge clk);
        drive(d8, 1'b0, 1'($urandom), $urandom, $urandom, 0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int          c0;
        bit          s;
        logic [31:0] ra, rb;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        repeat (3) @(negedge clk);
        chk("rst_res4",  32'(if4.ccx_res),  32'd0);
        chk("rst_resp4", 32'(if4.ccx_resp), 32'd0);
        chk("rst_busy4", 32'(if4.busy),     32'd0);
        chk("rst_res8",  32'(if8.ccx_res),  32'd0);
        chk("rst_resp8", 32'(if8.ccx_resp), 32'd0);
        chk("rst_busy8", 32'(if8.busy),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // AND, N=8
        c0 = cyc;
        issue(1'b0, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00, 8'h00);
        wait_to(c0 + 16);
        chk("and_idle_busy", 32'(if4.busy), 32'd0);

        // MUL small, busy window 1..47
        c0 = cyc;
        issue(1'b0, 1'b1, 32'h0001_0003, 32'h0000_0005, 8'h00);
        wait_to(c0 + 47);
        chk("mul_busy47", 32'(if4.busy), 32'd1);
        @(negedge clk);
        chk("mul_busy48", 32'(if4.busy), 32'd0);
        chk("mul_res48",  32'(if4.ccx_res), 32'd0);

        // MUL wrap cases
        c0 = cyc;
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00);
        wait_to(c0 + 48);
        c0 = cyc;
        issue(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002, 8'h00);
        wait_to(c0 + 48);

        // Extra reqs at cycles 5, 30, 47 ignored; back-to-back AND at 48
        c0 = cyc;
        issue(1'b0, 1'b1, 32'h0BAD_F00D, 32'h0000_1357, 8'b0010_0000);
        wait_to(c0 + 30);
        drive(1'b0, 1'b1, 1'b0, $urandom, $urandom, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, 0);
        wait_to(c0 + 47);
        drive(1'b0, 1'b1, 1'($urandom), $urandom, $urandom, 0);
        @(negedge clk);
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 8'h00);
        wait_to(c0 + 48 + 16);

        // Reset in cycle 20 of a MUL, with a simultaneous req
        c0 = cyc;
        issue(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00);
        wait_to(c0 + 20);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 0);
        sb4.delete();
        @(negedge clk);
        chk("abort_res",  32'(if4.ccx_res),  32'd0);
        chk("abort_resp", 32'(if4.ccx_resp), 32'd0);
        chk("abort_busy", 32'(if4.busy),     32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        repeat (50) @(negedge clk);
        c0 = cyc;
        issue(1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0FF0_0FF0, 8'h00);
        wait_to(c0 + 16);

        // Random back-to-back operations
        for (int i = 0; i < 6; i++) begin
            s  = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            c0 = cyc;
            issue(1'b0, s, ra, rb, 8'h00);
            wait_to(c0 + (s ? 48 : 16));
        end

        // CHUNKSIZE=8
        c0 = cyc;
        issue(1'b1, 1'b0, 32'hAABB_CCDD, 32'h0F0F_0F0F, 8'h00);
        wait_to(c0 + 8);
        c0 = cyc;
        issue(1'b1, 1'b1, 32'd7, 32'd6, 8'h00);
        wait_to(c0 + 40);
        chk("n4_idle_busy", 32'(if8.busy), 32'd0);

        for (int i = 0; i < 200 && (sb4.size() != 0 || sb8.size() != 0); i++) @(negedge clk);
        chk("pending4", 32'(sb4.size()), 32'd0);
        chk("pending8", 32'(sb8.size()), 32'd0);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
